// File: rtl/rv_dmem_arbiter.sv
// Data-memory arbiter and access sequencer for the uRV core: shares one memory bus between core (C) and debug/DMA (D).
// Define URV_DMEM_RR_EN for round-robin arbitration; otherwise C has fixed priority.
module rv_dmem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        c_req_i,
    input  logic        c_we_i,
    input  logic [31:0] c_addr_i,
    input  logic [31:0] c_data_s_i,
    input  logic [3:0]  c_sel_i,
    output logic [31:0] c_data_l_o,
    output logic        c_done_o,
    output logic        c_err_o,

    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_s_i,
    input  logic [3:0]  d_sel_i,
    output logic [31:0] d_data_l_o,
    output logic        d_done_o,
    output logic        d_err_o,

    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_data_s_o,
    output logic [3:0]  dm_data_select_o,
    output logic        dm_load_o,
    output logic        dm_store_o,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_ready_i,

    output logic        busy_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_C = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             grant_c;
    logic             grant_d;
    logic             prefer_d;
    logic             busy_any;
    logic             timeout_hit;
    logic             finish;
    logic [CNT_W-1:0] wait_cnt;

`ifdef URV_DMEM_RR_EN
    logic last_d;

    // On contention the requester that was not served last goes first.
    assign prefer_d = !last_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_d <= 1'b1;
        end else if (grant_c) begin
            last_d <= 1'b0;
        end else if (grant_d) begin
            last_d <= 1'b1;
        end
    end
`else
    assign prefer_d = 1'b0;
`endif

    assign busy_any    = (state != IDLE);
    assign timeout_hit = TIMEOUT_EN && busy_any && (wait_cnt == CNT_LAST) && !dm_ready_i;
    assign finish      = busy_any && (dm_ready_i || timeout_hit);
    assign busy_o      = busy_any;

    always_comb begin
        state_next = state;
        grant_c    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (c_req_i && d_req_i) begin
                    grant_d = prefer_d;
                    grant_c = !prefer_d;
                end else begin
                    grant_c = c_req_i;
                    grant_d = d_req_i;
                end
                if (grant_c) begin
                    state_next = BUSY_C;
                end else if (grant_d) begin
                    state_next = BUSY_D;
                end
            end
            BUSY_C, BUSY_D: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant latches the winner's request; the strobe drops when the access finishes.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dm_addr_o        <= '0;
            dm_data_s_o      <= '0;
            dm_data_select_o <= '0;
            dm_load_o        <= 1'b0;
            dm_store_o       <= 1'b0;
            wait_cnt         <= '0;
        end else if (grant_c) begin
            dm_addr_o        <= c_addr_i;
            dm_data_s_o      <= c_data_s_i;
            dm_data_select_o <= c_sel_i;
            dm_load_o        <= !c_we_i;
            dm_store_o       <= c_we_i;
            wait_cnt         <= '0;
        end else if (grant_d) begin
            dm_addr_o        <= d_addr_i;
            dm_data_s_o      <= d_data_s_i;
            dm_data_select_o <= d_sel_i;
            dm_load_o        <= !d_we_i;
            dm_store_o       <= d_we_i;
            wait_cnt         <= '0;
        end else if (finish) begin
            dm_load_o        <= 1'b0;
            dm_store_o       <= 1'b0;
        end else if (busy_any && TIMEOUT_EN && (wait_cnt != CNT_LAST)) begin
            wait_cnt         <= wait_cnt + 1'b1;
        end
    end

    // Completion is combinational with ready; an access being killed by reset reports nothing.
    always_comb begin
        c_done_o   = rst_n_i && (state == BUSY_C) && finish;
        c_err_o    = rst_n_i && (state == BUSY_C) && timeout_hit;
        d_done_o   = rst_n_i && (state == BUSY_D) && finish;
        d_err_o    = rst_n_i && (state == BUSY_D) && timeout_hit;
        c_data_l_o = '0;
        d_data_l_o = '0;
        if (c_done_o && dm_ready_i && !dm_store_o) begin
            c_data_l_o = dm_data_l_i;
        end
        if (d_done_o && dm_ready_i && !dm_store_o) begin
            d_data_l_o = dm_data_l_i;
        end
    end

endmodule

// File: tb/tb_rv_dmem_arbiter.sv
// Self-checking bench for rv_dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rv_dmem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_data_s, d_addr, d_data_s;
    logic [3:0]  c_sel, d_sel;
    logic [31:0] c_data_l, d_data_l;
    logic        c_done, c_err, d_done, d_err;
    logic [31:0] dm_addr, dm_data_s, dm_data_l;
    logic [3:0]  dm_sel;
    logic        dm_load, dm_store, dm_ready, busy;

    rv_dmem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_data_s_i(c_data_s), .c_sel_i(c_sel),
        .c_data_l_o(c_data_l), .c_done_o(c_done), .c_err_o(c_err),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_data_s_i(d_data_s), .d_sel_i(d_sel),
        .d_data_l_o(d_data_l), .d_done_o(d_done), .d_err_o(d_err),
        .dm_addr_o(dm_addr), .dm_data_s_o(dm_data_s), .dm_data_select_o(dm_sel),
        .dm_load_o(dm_load), .dm_store_o(dm_store), .dm_data_l_i(dm_data_l), .dm_ready_i(dm_ready),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the bus, how many busy cycles have elapsed, what was latched.
    int          m_owner = 0;   // 0 none, 1 C, 2 D
    int          m_waited = 0;
    int          m_win;
    logic [31:0] m_addr = '0, m_data = '0;
    logic [3:0]  m_sel = '0;
    logic        m_we = 1'b0;
    bit          m_last_d = 1'b1;
    bit          m_c_fin = 1'b0, m_d_fin = 1'b0;

    function automatic bit m_timeout();
        return (m_owner != 0) && rst_n && !dm_ready && (TO != 0) && (m_waited + 1 == TO);
    endfunction

    function automatic bit m_finish();
        return (m_owner != 0) && rst_n && (dm_ready || ((TO != 0) && (m_waited + 1 == TO)));
    endfunction

    initial forever begin
        @(posedge clk);
        m_c_fin = m_finish() && (m_owner == 1);
        m_d_fin = m_finish() && (m_owner == 2);
        if (!rst_n) begin
            m_owner = 0; m_waited = 0; m_addr = '0; m_data = '0; m_sel = '0; m_we = 1'b0; m_last_d = 1'b1;
        end else if (m_owner != 0) begin
            if (m_finish()) m_owner = 0;
            else m_waited = m_waited + 1;
        end else begin
            m_win = 0;
            if (c_req && d_req) begin
`ifdef URV_DMEM_RR_EN
                m_win = m_last_d ? 1 : 2;
`else
                m_win = 1;
`endif
            end else if (c_req) m_win = 1;
            else if (d_req) m_win = 2;
            if (m_win != 0) begin
                m_owner  = m_win;
                m_waited = 0;
                m_addr   = (m_win == 1) ? c_addr : d_addr;
                m_data   = (m_win == 1) ? c_data_s : d_data_s;
                m_sel    = (m_win == 1) ? c_sel : d_sel;
                m_we     = (m_win == 1) ? c_we : d_we;
                m_last_d = (m_win == 2);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            bit fin, to, bz, cd, dd;
            bz  = (m_owner != 0);
            fin = m_finish();
            to  = m_timeout();
            cd  = fin && (m_owner == 1);
            dd  = fin && (m_owner == 2);
            chk("busy", 32'(busy), 32'(bz));
            chk("dm_load", 32'(dm_load), 32'(bz && !m_we));
            chk("dm_store", 32'(dm_store), 32'(bz && m_we));
            chk("dm_addr", dm_addr, m_addr);
            chk("dm_data_s", dm_data_s, m_data);
            chk("dm_sel", 32'(dm_sel), 32'(m_sel));
            chk("c_done", 32'(c_done), 32'(cd));
            chk("c_err", 32'(c_err), 32'(to && m_owner == 1));
            chk("c_data_l", c_data_l, (cd && dm_ready && !m_we) ? dm_data_l : 32'h0);
            chk("d_done", 32'(d_done), 32'(dd));
            chk("d_err", 32'(d_err), 32'(to && m_owner == 2));
            chk("d_data_l", d_data_l, (dd && dm_ready && !m_we) ? dm_data_l : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        c_req = 0; c_we = 0; c_addr = 0; c_data_s = 0; c_sel = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_data_s = 0; d_sel = 0;
        dm_ready = 0; dm_data_l = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic new_c();
        c_we = 1'($urandom_range(0, 1)); c_addr = $urandom; c_data_s = $urandom; c_sel = 4'($urandom_range(0, 15));
    endtask

    task automatic new_d();
        d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_data_s = $urandom; d_sel = 4'($urandom_range(0, 15));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int loads, dones, ddones, first_done, errc, stray, busyc;
        logic [31:0] got;
        int g[4];
        int ng;

        rst_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dm_load", 32'(dm_load), 32'h0);
        chk("rst_dm_store", 32'(dm_store), 32'h0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_data_s", dm_data_s, 32'h0);
        chk("rst_dm_sel", 32'(dm_sel), 32'h0);
        chk("rst_done", 32'({c_done, d_done, c_err, d_err}), 32'h0);
        chk("rst_data_l", c_data_l | d_data_l, 32'h0);
        cmp_en = 1'b1;
        tick();
        rst_n = 1;

        // Single C load with three wait cycles.
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h100; c_sel = 4'hF; dm_data_l = 32'hDEADBEEF;
        loads = 0; dones = 0; ddones = 0; got = 0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            dm_ready = (i == 4);
            if (i == 5) c_req = 0;
            @(negedge clk);
            loads += int'(dm_load);
            if (c_done) begin dones++; got = c_data_l; end
            ddones += int'(d_done);
            tick();
        end
        chk("c_load_cycles", 32'(loads), 32'd4);
        chk("c_done_count", 32'(dones), 32'd1);
        chk("c_load_data", got, 32'hDEADBEEF);
        chk("c_load_no_d_done", 32'(ddones), 32'd0);

        // Continuous contention, zero wait.
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h1000;
        d_req = 1; d_we = 0; d_addr = 32'h2000;
        dm_ready = 1;
        ng = 0;
        repeat (8) begin
            @(negedge clk);
            if (ng < 4 && c_done) begin g[ng] = 1; ng++; end
            else if (ng < 4 && d_done) begin g[ng] = 2; ng++; end
            tick();
        end
        c_req = 0; d_req = 0; dm_ready = 0;
        chk("contend_grants", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef URV_DMEM_RR_EN
            chk($sformatf("contend_grant%0d", i), 32'(g[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
`else
            chk($sformatf("contend_grant%0d", i), 32'(g[i]), 32'd1);
`endif
        end

        // D store.
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h200; d_data_s = 32'h12345678; d_sel = 4'h3; dm_data_l = 32'hCAFEF00D;
        tick();
        @(negedge clk);
        chk("d_st_store", 32'(dm_store), 32'h1);
        chk("d_st_load", 32'(dm_load), 32'h0);
        chk("d_st_addr", dm_addr, 32'h200);
        chk("d_st_data", dm_data_s, 32'h12345678);
        chk("d_st_sel", 32'(dm_sel), 32'h3);
        tick();
        dm_ready = 1;
        @(negedge clk);
        chk("d_st_done", 32'(d_done), 32'h1);
        chk("d_st_data_l", d_data_l, 32'h0);
        chk("d_st_c_done", 32'(c_done), 32'h0);
        tick();
        d_req = 0; dm_ready = 0;

        // Timeout with no ready, then a stray ready.
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h40;
        first_done = 0; errc = 0; dones = 0; stray = 0; busyc = 0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (c_done) begin
                dones++;
                if (first_done == 0) first_done = i;
                errc += int'(c_err);
            end
            tick();
        end
        c_req = 0;
        for (int j = 1; j <= 3; j++) begin
            dm_ready = (j == 2);
            @(negedge clk);
            stray += int'(c_done | d_done | c_err | d_err);
            busyc += int'(busy);
            tick();
        end
        dm_ready = 0;
        chk("to_done_cycle", 32'(first_done), 32'd4);
        chk("to_done_count", 32'(dones), 32'd1);
        chk("to_err_count", 32'(errc), 32'd1);
        chk("to_stray_done", 32'(stray), 32'd0);
        chk("to_stray_busy", 32'(busyc), 32'd0);

        // Reset in the middle of a D access.
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h280;
        tick();
        @(negedge clk);
        chk("rk_busy_before", 32'(busy), 32'h1);
        tick();
        rst_n = 0; d_req = 0;
        @(negedge clk);
        chk("rk_no_done_in_rst", 32'(d_done), 32'h0);
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("rk_load_after", 32'(dm_load), 32'h0);
        chk("rk_busy_after", 32'(busy), 32'h0);
        chk("rk_d_done_after", 32'(d_done), 32'h0);
        tick();
        c_req = 1; c_we = 0; c_addr = 32'h300; dm_data_l = 32'h0BADC0DE;
        tick();
        dm_ready = 1;
        @(negedge clk);
        chk("rk_c_load", 32'(dm_load), 32'h1);
        chk("rk_c_addr", dm_addr, 32'h300);
        chk("rk_c_done", 32'(c_done), 32'h1);
        chk("rk_c_data", c_data_l, 32'h0BADC0DE);
        tick();
        c_req = 0; dm_ready = 0;

        // Randomized traffic with occasional resets.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 199) == 0) rst_n = 0;
            if (c_req) begin
                if (m_c_fin) begin
                    if ($urandom_range(0, 1) == 1) new_c();
                    else c_req = 0;
                end
            end else begin
                new_c();
                c_req = ($urandom_range(0, 2) == 0);
            end
            if (d_req) begin
                if (m_d_fin) begin
                    if ($urandom_range(0, 1) == 1) new_d();
                    else d_req = 0;
                end
            end else begin
                new_d();
                d_req = ($urandom_range(0, 2) == 0);
            end
            dm_ready  = ($urandom_range(0, 2) == 0);
            dm_data_l = $urandom;
            tick();
        end
        clear_inputs();
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
